// File: rtl/ps2_receiver_if.sv
// PS/2 receiver bus: raw keyboard lines, FIFO pop/clear strobes and the
// receiver's FIFO head, occupancy and sticky error flags.
interface ps2_receiver_if #(
  parameter int unsigned FIFO_DEPTH = 8
) ();

  logic                          ps2_clk;
  logic                          ps2_data;
  logic                          rd;
  logic                          clr_err;
  logic [7:0]                    data;
  logic                          ready;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          parity_err;
  logic                          frame_err;
  logic                          overflow;

  // Host / keyboard side
  modport master (
    output ps2_clk, ps2_data, rd, clr_err,
    input  data, ready, count, parity_err, frame_err, overflow
  );

  // Receiver side
  modport slave (
    input  ps2_clk, ps2_data, rd, clr_err,
    output data, ready, count, parity_err, frame_err, overflow
  );

endinterface

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronises the raw bus, decodes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) and queues good bytes in a FIFO.
module ps2_receiver #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input logic           clk_in,
  input logic           rst,
  ps2_receiver_if.slave bus
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT);

  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT - 1);
  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  // Synchronisers and edge history
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;

  // Frame decoder
  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             parity_ok;
  logic             push, set_perr, set_ferr;

  // FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            empty, full, pop, wr_en, set_ovf;

  // Sticky flags
  logic perr_q, ferr_q, ovf_q;

  // Two-flop synchronisers plus one history flop on the clock line; idle bus is high
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= bus.ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= bus.ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall      = clk_prev_q & ~clk_sync_q;
  // Odd parity over data plus parity bit
  assign parity_ok = ^{shift_q, par_q};

  // Frame decoder next state; data is sampled on the detected falling edge
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    idle_d    = idle_q;
    push      = 1'b0;
    set_perr  = 1'b0;
    set_ferr  = 1'b0;
    if (fall) begin
      idle_d = '0;
      case (state_q)
        StIdle: begin
          if (!data_sync_q) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = data_sync_q;
          state_d = StStop;
        end
        StStop: begin
          state_d  = StIdle;
          set_perr = ~parity_ok;
          set_ferr = ~data_sync_q;
          push     = parity_ok & data_sync_q;
        end
        default: state_d = StIdle;
      endcase
    end else begin
      // Saturate so a long-idle bus never wraps the counter
      if (idle_q != IdleMax) begin
        idle_d = idle_q + 1'b1;
      end
      // Stalled partial frame: drop it silently
      if (state_q != StIdle && idle_q == IdleMax) begin
        state_d   = StIdle;
        bit_cnt_d = 3'd0;
        shift_d   = 8'h00;
      end
    end
  end

  // Frame decoder state
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      idle_q    <= idle_d;
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign pop     = bus.rd & ~empty;
  // A same-cycle pop frees the slot the push lands in, even when full
  assign wr_en   = push & (~full | pop);
  assign set_ovf = push & full & ~pop;

  // FIFO occupancy next value
  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO storage; contents need no reset since data is masked while empty
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Sticky error flags: clear, but a same-cycle new error wins
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      perr_q <= (perr_q & ~bus.clr_err) | set_perr;
      ferr_q <= (ferr_q & ~bus.clr_err) | set_ferr;
      ovf_q  <= (ovf_q & ~bus.clr_err) | set_ovf;
    end
  end

  assign bus.data       = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.ready      = ~empty;
  assign bus.count      = count_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: directed PS/2 frames, a queue-based reference of
// the FIFO and flags, a per-cycle compare and hand-computed spot checks.
module tb_ps2_receiver;

  localparam int unsigned Depth = 8;
  localparam int unsigned To    = 200;
  localparam int          Half  = 10;

  logic clk;
  logic rst;

  ps2_receiver_if #(.FIFO_DEPTH(Depth)) bus ();

  ps2_receiver #(
    .FIFO_DEPTH(Depth),
    .TIMEOUT   (To)
  ) dut (
    .clk_in(clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: byte queue, sticky flags, one pending frame outcome
  logic [7:0] q[$];
  logic       m_perr = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       ev_pending = 1'b0;
  int         ev_cyc = 0;
  logic [7:0] ev_byte = 8'h00;
  logic       ev_perr = 1'b0;
  logic       ev_ferr = 1'b0;
  logic       done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge: pop first, then clear, then frame outcome
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
      ev_pending = 1'b0;
    end else begin
      if (bus.rd && q.size() != 0) void'(q.pop_front());
      if (bus.clr_err) begin
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
      end
      if (ev_pending && ev_cyc == cyc) begin
        ev_pending = 1'b0;
        if (ev_perr) m_perr = 1'b1;
        if (ev_ferr) m_ferr = 1'b1;
        if (!ev_perr && !ev_ferr) begin
          if (q.size() < Depth) q.push_back(ev_byte);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare, just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        chk("cyc_ready", 32'(bus.ready), 32'(q.size() != 0));
        chk("cyc_count", 32'(bus.count), 32'(q.size()));
        if (q.size() != 0) chk("cyc_data", 32'(bus.data), 32'(q[0]));
        chk("cyc_parity_err", 32'(bus.parity_err), 32'(m_perr));
        chk("cyc_frame_err", 32'(bus.frame_err), 32'(m_ferr));
        chk("cyc_overflow", 32'(bus.overflow), 32'(m_ovf));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.ps2_data = b;
    repeat (Half - 1) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (Half) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  // Full frame; s_rd/s_clr strobe during the cycle the outcome takes effect
  task automatic send_frame(input logic [7:0] b, input logic p, input logic stop,
                            input logic s_rd, input logic s_clr);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    @(negedge clk);
    bus.ps2_data = stop;
    repeat (Half - 1) @(negedge clk);
    bus.ps2_clk = 1'b0;
    // 2 sync flops + 1 register stage after the driven edge
    ev_byte    = b;
    ev_perr    = ((^b) ^ p) != 1'b1;
    ev_ferr    = ~stop;
    ev_cyc     = cyc + 3;
    ev_pending = 1'b1;
    repeat (2) @(negedge clk);
    bus.rd      = s_rd;
    bus.clr_err = s_clr;
    @(negedge clk);
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    repeat (Half - 3) @(negedge clk);
    bus.ps2_clk = 1'b1;
    @(negedge clk);
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic good_frame(input logic [7:0] b);
    send_frame(b, ~(^b), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  logic [7:0] last;

  initial begin
    rst = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rd       = 1'b0;
    bus.clr_err  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_data", 32'(bus.data), 32'h00);
    chk("rst_flags", 32'({bus.parity_err, bus.frame_err, bus.overflow}), 32'd0);
    rst = 1'b0;

    // Single good frame, then pop; extra pop on empty is ignored
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("f1c_ready", 32'(bus.ready), 32'd1);
    chk("f1c_data", 32'(bus.data), 32'h1C);
    chk("f1c_count", 32'(bus.count), 32'd1);
    pulse_rd();
    chk("pop_ready", 32'(bus.ready), 32'd0);
    chk("pop_count", 32'(bus.count), 32'd0);
    pulse_rd();
    chk("empty_rd_count", 32'(bus.count), 32'd0);

    // Parity error, then clear
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("perr_set", 32'(bus.parity_err), 32'd1);
    chk("perr_ready", 32'(bus.ready), 32'd0);
    pulse_clr();
    chk("perr_clr", 32'(bus.parity_err), 32'd0);

    // Frame error with good parity
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ferr_set", 32'(bus.frame_err), 32'd1);
    chk("ferr_noperr", 32'(bus.parity_err), 32'd0);
    chk("ferr_ready", 32'(bus.ready), 32'd0);

    // Both errors while clr_err is high in the same cycle: set wins
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("both_perr", 32'(bus.parity_err), 32'd1);
    chk("both_ferr", 32'(bus.frame_err), 32'd1);
    pulse_clr();
    chk("both_clr", 32'({bus.parity_err, bus.frame_err}), 32'd0);

    // Nine frames with no reads: ninth overflows
    for (int i = 1; i <= 9; i++) good_frame(8'(i));
    chk("ovf_count", 32'(bus.count), 32'd8);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_head", 32'(bus.data), 32'h01);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_pop_data", 32'(bus.data), 32'(i));
      pulse_rd();
    end
    chk("ovf_drained", 32'(bus.ready), 32'd0);
    pulse_clr();
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // Full FIFO, pop during the push cycle
    for (int i = 8'h11; i <= 8'h18; i++) good_frame(8'(i));
    chk("full_count", 32'(bus.count), 32'd8);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pp_count", 32'(bus.count), 32'd8);
    chk("pp_ovf", 32'(bus.overflow), 32'd0);
    chk("pp_head", 32'(bus.data), 32'h12);
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last = bus.data;
      pulse_rd();
    end
    chk("pp_last", 32'(last), 32'hAA);
    chk("pp_empty", 32'(bus.count), 32'd0);

    // Start bit plus three data bits, then stall past the timeout
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (To + 20) @(negedge clk);
    good_frame(8'hF0);
    chk("to_count", 32'(bus.count), 32'd1);
    chk("to_data", 32'(bus.data), 32'hF0);
    chk("to_flags", 32'({bus.parity_err, bus.frame_err, bus.overflow}), 32'd0);
    pulse_rd();

    // Reset in the middle of a frame with a byte already queued
    good_frame(8'h33);
    chk("pre_rst_count", 32'(bus.count), 32'd1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(bus.count), 32'd0);
    chk("async_rst_ready", 32'(bus.ready), 32'd0);
    chk("async_rst_data", 32'(bus.data), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    good_frame(8'h5A);
    chk("post_rst_count", 32'(bus.count), 32'd1);
    chk("post_rst_data", 32'(bus.data), 32'h5A);

    repeat (3) @(negedge clk);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 FIFO_DEPTH, 8, scancode FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 TIMEOUT, 50000, clk_in cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk_in  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ps2_clk  in  1  raw keyboard clock, asynchronous to clk_in.
REQ-006 ps2_data  in  1  raw keyboard data, asynchronous to clk_in.
REQ-007 rd  in  1  pop request; one entry popped per cycle while high and ready=1.
REQ-008 clr_err  in  1  synchronous clear of sticky error flags.
REQ-009 data  out  8  FIFO head byte; valid only while ready=1.
REQ-010 ready  out  1  high while FIFO non-empty.
REQ-011 count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 parity_err  out  1  sticky: a frame failed odd parity.
REQ-013 frame_err  out  1  sticky: a frame had stop bit 0.
REQ-014 overflow  out  1  sticky: a good frame was dropped because the FIFO was full.

Function
REQ-015 ps2_clk and ps2_data SHALL each pass a 2-flop synchroniser; a falling edge SHALL be detected when the synchronised ps2_clk is 0 and its previous registered value is 1; ps2_data SHALL be sampled in that same cycle.
REQ-016 FSM states: IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: on an edge with data=0 (start bit) -> DATA with bit counter 0; on an edge with data=1 -> stay IDLE.
REQ-018 DATA: on each edge, shift the sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-019 PARITY: on an edge, store the bit -> STOP; parity is good when the XOR of the 8 data bits and the parity bit equals 1.
REQ-020 STOP: on an edge -> IDLE; stop=1 with good parity pushes the byte; bad parity sets parity_err; stop=0 sets frame_err; both errors may set together; an errored frame is never pushed.
REQ-021 Idle counter resets to 0 on every edge and increments otherwise; in a non-IDLE state, reaching TIMEOUT-1 SHALL return the FSM to IDLE, discard the partial byte and set no error flag.
REQ-022 Push latency: ready/count SHALL reflect the byte on the clk_in edge after the stop-bit sample cycle.
REQ-023 data SHALL be the entry at the read pointer; pointers wrap modulo FIFO_DEPTH.
REQ-024 rd with ready=0 SHALL be ignored with no pointer or count change.
REQ-025 Push to a full FIFO without a same-cycle pop: byte dropped, overflow=1, count stays FIFO_DEPTH.
REQ-026 Push and pop in the same cycle, including when full: both occur, count unchanged, overflow not set.
REQ-027 clr_err=1 clears all three sticky flags; if a new error is detected in the same cycle, the set wins.

Reset
REQ-028 rst=1 SHALL immediately force: FSM IDLE; bit counter, idle counter and pointers 0; count=0, ready=0, data=0x00; all error flags 0; synchroniser flops 1 (idle bus).
REQ-029 A frame in progress when rst asserts SHALL be discarded; after release, reception SHALL resume at the next start bit.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1 -> ready=1, data=0x1C, count=1; one rd pulse -> ready=0, count=0.
REQ-031 Frame 0x1C, parity 1 -> parity_err=1, ready=0; clr_err pulse -> parity_err=0.
REQ-032 Nine good frames 0x01..0x09 with no rd -> count=8, overflow=1, data=0x01; eight pops return 0x01..0x08.
REQ-033 Start bit plus 3 data bits, then TIMEOUT idle cycles, then frame 0xF0 with parity 1 -> exactly one entry 0xF0, no error flags.
REQ-034 FIFO full; rd held high during the cycle frame 0xAA (parity 1) is pushed -> count stays 8, overflow=0, 0xAA is the last entry read back.
REQ-035 rst pulsed after the 4th data bit of a frame, then a full 0x5A frame (parity 1) -> only 0x5A in the FIFO, count=1.
